// File: rtl/cache_victim_sel_pkg.sv
// Shared cache definitions: victim selector FSM states and the default associativity.
package cache_victim_sel_pkg;

    localparam int unsigned DEFAULT_WAYS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PICK = 2'd1,
        RESP = 2'd2
    } victim_state_t;

endpackage

// File: rtl/cache_victim_sel_way_prio_enc.sv
// Lowest-set-bit encoder over a WAYS-wide vector, searching upward from a start offset with wrap-around.
module way_prio_enc #(
    parameter int unsigned WAYS  = 4,
    parameter int unsigned IDX_W = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]  vec,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] pos;

    // Scan from the far end back toward start so the nearest hit is the one kept.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            pos = start + IDX_W'(i);
            if (vec[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/cache_victim_sel.sv
// Victim way selector: invalid-way first, then LFSR draws with bounded retry, then round-robin fallback.
module cache_victim_sel
    import cache_victim_sel_pkg::*;
#(
    parameter int unsigned WAYS      = DEFAULT_WAYS,
    parameter int unsigned MAX_RETRY = 4,
    parameter int unsigned IDX_W     = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WAYS-1:0]  req_valid_mask,
    input  logic [WAYS-1:0]  req_lock_mask,
    input  logic [31:0]      rnd,
    output logic             rnd_update,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [IDX_W-1:0] resp_way,
    output logic [WAYS-1:0]  resp_onehot,
    output logic             resp_fail
);

    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

    victim_state_t      state_q, state_d;
    logic [WAYS-1:0]    vmask_q, vmask_d;
    logic [WAYS-1:0]    lmask_q, lmask_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   way_q, way_d;
    logic [WAYS-1:0]    onehot_q, onehot_d;
    logic               fail_q, fail_d;

    logic               inv_found, rr_found;
    logic [IDX_W-1:0]   inv_idx, rr_idx;
    logic [IDX_W-1:0]   cand;

    assign cand = rnd[IDX_W-1:0];

    way_prio_enc #(.WAYS(WAYS), .IDX_W(IDX_W)) u_inv_enc (
        .vec   (~vmask_q & ~lmask_q),
        .start (IDX_W'(0)),
        .found (inv_found),
        .idx   (inv_idx)
    );

    way_prio_enc #(.WAYS(WAYS), .IDX_W(IDX_W)) u_rr_enc (
        .vec   (~lmask_q),
        .start (rr_q),
        .found (rr_found),
        .idx   (rr_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            vmask_q  <= '0;
            lmask_q  <= '0;
            retry_q  <= '0;
            rr_q     <= '0;
            way_q    <= '0;
            onehot_q <= '0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vmask_q  <= vmask_d;
            lmask_q  <= lmask_d;
            retry_q  <= retry_d;
            rr_q     <= rr_d;
            way_q    <= way_d;
            onehot_q <= onehot_d;
            fail_q   <= fail_d;
        end
    end

    // Rule order in PICK: all locked, invalid-unlocked, retry exhausted, random draw.
    always_comb begin
        state_d    = state_q;
        vmask_d    = vmask_q;
        lmask_d    = lmask_q;
        retry_d    = retry_q;
        rr_d       = rr_q;
        way_d      = way_q;
        onehot_d   = onehot_q;
        fail_d     = fail_q;
        rnd_update = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    vmask_d = req_valid_mask;
                    lmask_d = req_lock_mask;
                    retry_d = '0;
                    state_d = PICK;
                end
            end
            PICK: begin
                if (&lmask_q) begin
                    fail_d   = 1'b1;
                    way_d    = '0;
                    onehot_d = '0;
                    state_d  = RESP;
                end else if (inv_found) begin
                    way_d    = inv_idx;
                    onehot_d = WAYS'(1) << inv_idx;
                    state_d  = RESP;
                end else if (retry_q == RETRY_W'(MAX_RETRY)) begin
                    way_d    = rr_idx;
                    onehot_d = WAYS'(rr_found) << rr_idx;
                    rr_d     = rr_idx + IDX_W'(1);
                    state_d  = RESP;
                end else begin
                    rnd_update = 1'b1;
                    if (!lmask_q[cand]) begin
                        way_d    = cand;
                        onehot_d = WAYS'(1) << cand;
                        state_d  = RESP;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                    end
                end
            end
            RESP: begin
                if (resp_ready) begin
                    way_d    = '0;
                    onehot_d = '0;
                    fail_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == RESP);
    assign resp_way    = way_q;
    assign resp_onehot = onehot_q;
    assign resp_fail   = fail_q;

endmodule
